inst_mem_loader: RTL and testbench



---
 rtl/inst_mem_loader_pkg.sv | 11 +
 rtl/inst_mem_loader_imem_array.sv | 22 ++
 rtl/inst_mem_loader.sv | 106 ++++++++++
 tb/tb_inst_mem_loader.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/inst_mem_loader_pkg.sv
// Shared constants and FSM encoding for the instruction memory loader.
// TEXT_BASE matches the CPU pc reset value.
package inst_mem_loader_pkg;
  localparam int          WORD_W    = 32;
  localparam logic [31:0] TEXT_BASE = 32'h00400000;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } state_t;
endpackage

// File: rtl/inst_mem_loader_imem_array.sv
// 2^ADRS_BITS x 32 register array, one sync write, one async read.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read). No reset.
module inst_mem_loader_imem_array
  import inst_mem_loader_pkg::*;
#(
  parameter int ADRS_BITS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [ADRS_BITS-1:0] i_waddr,
  input  logic [WORD_W-1:0]    i_wdata,
  input  logic [ADRS_BITS-1:0] i_raddr,
  output logic [WORD_W-1:0]    o_rdata
);
  logic [WORD_W-1:0] r_mem [2**ADRS_BITS];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/inst_mem_loader.sv
// Instruction fetch responder with a little-endian byte-stream loader.
// Ports: clk_cpu/reset, pc->inst fetch, ld_* stream, busy/ld_err/word_count.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int          ADRS_BITS = 8,
  parameter logic [31:0] BASE_ADRS = TEXT_BASE,
  parameter logic [31:0] NOP_WORD  = 32'h00000000
) (
  input  logic               clk_cpu,
  input  logic               reset,
  input  logic [31:0]        pc,
  output logic [31:0]        inst,
  input  logic               ld_start,
  input  logic               ld_valid,
  input  logic [7:0]         ld_byte,
  input  logic               ld_end,
  output logic               busy,
  output logic               ld_err,
  output logic [ADRS_BITS:0] word_count
);
  state_t             r_state;
  logic               r_busy;
  logic               r_err;
  logic [ADRS_BITS:0] r_wr_ptr;
  logic [1:0]         r_cnt;
  logic [31:0]        r_buf;

  logic        w_load;
  logic        w_acc;
  logic        w_full;
  logic        w_need;
  logic        w_room;
  logic        w_we;
  logic [1:0]  w_cnt_nx;
  logic [31:0] w_buf_nx;
  logic [31:0] w_off;
  logic [31:0] w_rdata;
  logic        w_hit;

  // A restart pulse overrides any byte or end seen in the same cycle.
  always_comb begin
    w_load   = (r_state == S_LOAD) && !ld_start;
    w_acc    = w_load && ld_valid && !r_err;
    w_buf_nx = r_buf;
    if (w_acc) w_buf_nx[8*r_cnt +: 8] = ld_byte;
    w_cnt_nx = r_cnt + {1'b0, w_acc};
    w_full   = w_acc && (r_cnt == 2'd3);
    // A byte completing a word wraps w_cnt_nx to 0, so no padded extra.
    w_need   = w_load && (w_full || (ld_end && w_cnt_nx != 2'd0));
    w_room   = !r_wr_ptr[ADRS_BITS];
    w_we     = w_need && w_room;
  end

  // Wrap subtraction makes pc below base look far out of range.
  // Base is word-aligned, so offset low bits equal pc low bits.
  assign w_off = pc - BASE_ADRS;
  assign w_hit = (w_off[1:0] == 2'b00)
              && (w_off[31:ADRS_BITS+2] == '0)
              && !r_busy;
  assign inst  = w_hit ? w_rdata : NOP_WORD;

  inst_mem_loader_imem_array #(
    .ADRS_BITS(ADRS_BITS)
  ) u_mem (
    .i_clk  (clk_cpu),
    .i_we   (w_we),
    .i_waddr(r_wr_ptr[ADRS_BITS-1:0]),
    .i_wdata(w_buf_nx),
    .i_raddr(w_off[ADRS_BITS+1:2]),
    .o_rdata(w_rdata)
  );

  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_wr_ptr <= '0;
      r_cnt    <= 2'd0;
      r_buf    <= '0;
    end else if (ld_start) begin
      r_state  <= S_LOAD;
      r_busy   <= 1'b1;
      r_err    <= 1'b0;
      r_wr_ptr <= '0;
      r_cnt    <= 2'd0;
      r_buf    <= '0;
    end else if (r_state == S_LOAD) begin
      r_cnt <= w_cnt_nx;
      r_buf <= w_full ? '0 : w_buf_nx;
      if (w_we) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_need && !w_room) r_err <= 1'b1;
      if (ld_end) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_cnt   <= 2'd0;
        r_buf   <= '0;
      end
    end
  end

  assign busy       = r_busy;
  assign ld_err     = r_err;
  assign word_count = r_wr_ptr;
endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: a 256-word instance and a
// 4-word instance for the overflow path.
module tb_inst_mem_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [31:0] pc_a = 32'h0;
  logic [31:0] inst_a;
  logic        st_a = 0, vl_a = 0, en_a = 0;
  logic [7:0]  by_a = 0;
  logic        busy_a, err_a;
  logic [8:0]  wc_a;

  logic [31:0] pc_b = 32'h0;
  logic [31:0] inst_b;
  logic        st_b = 0, vl_b = 0, en_b = 0;
  logic [7:0]  by_b = 0;
  logic        busy_b, err_b;
  logic [2:0]  wc_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_mem_loader #(.ADRS_BITS(8)) u_big (
    .clk_cpu(clk), .reset(rst), .pc(pc_a), .inst(inst_a),
    .ld_start(st_a), .ld_valid(vl_a), .ld_byte(by_a),
    .ld_end(en_a), .busy(busy_a), .ld_err(err_a),
    .word_count(wc_a)
  );

  inst_mem_loader #(.ADRS_BITS(2)) u_small (
    .clk_cpu(clk), .reset(rst), .pc(pc_b), .inst(inst_b),
    .ld_start(st_b), .ld_valid(vl_b), .ld_byte(by_b),
    .ld_end(en_b), .busy(busy_b), .ld_err(err_b),
    .word_count(wc_b)
  );

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(int s, logic st, logic vl,
                     logic [7:0] b, logic en);
    if (s == 0) begin
      st_a = st; vl_a = vl; by_a = b; en_a = en;
    end else begin
      st_b = st; vl_b = vl; by_b = b; en_b = en;
    end
    @(posedge clk); #1;
    st_a = 0; vl_a = 0; by_a = 0; en_a = 0;
    st_b = 0; vl_b = 0; by_b = 0; en_b = 0;
  endtask

  task automatic fetch(int s, logic [31:0] p,
                       logic [31:0] exp, string tag);
    if (s == 0) pc_a = p; else pc_b = p;
    #1;
    chk(tag, (s == 0) ? inst_a : inst_b, exp);
  endtask

  initial begin
    logic [31:0] w;
    #12;
    chk("rst_busy", {31'b0, busy_a}, 32'd0);
    chk("rst_err", {31'b0, err_a}, 32'd0);
    chk("rst_wc", {23'b0, wc_a}, 32'd0);
    chk("rst_wc_s", {29'b0, wc_b}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Fill all 256 words with C0DE0000|index.
    cyc(0, 1, 0, 8'h00, 0);
    chk("full_busy", {31'b0, busy_a}, 32'd1);
    for (int i = 0; i < 256; i++) begin
      w = 32'hC0DE0000 | i;
      for (int k = 0; k < 4; k++) cyc(0, 0, 1, w[8*k +: 8], 0);
    end
    cyc(0, 0, 0, 8'h00, 1);
    chk("full_wc", {23'b0, wc_a}, 32'd256);
    chk("full_err", {31'b0, err_a}, 32'd0);
    fetch(0, 32'h004003FC, 32'hC0DE00FF, "pc_last");
    fetch(0, 32'h00400400, 32'h00000000, "pc_past_end");
    fetch(0, 32'h003FFFFC, 32'h00000000, "pc_below");
    fetch(0, 32'h00400000, 32'hC0DE0000, "pc_w0_full");

    // Two words: 13 00 08 20 | 13 00 09 21.
    cyc(0, 1, 0, 8'h00, 0);
    chk("busy_rise", {31'b0, busy_a}, 32'd1);
    fetch(0, 32'h00400000, 32'h00000000, "busy_blank");
    cyc(0, 0, 1, 8'h13, 0); cyc(0, 0, 1, 8'h00, 0);
    cyc(0, 0, 1, 8'h08, 0); cyc(0, 0, 1, 8'h20, 0);
    cyc(0, 0, 1, 8'h13, 0); cyc(0, 0, 1, 8'h00, 0);
    cyc(0, 0, 1, 8'h09, 0); cyc(0, 0, 1, 8'h21, 0);
    chk("busy_before_end", {31'b0, busy_a}, 32'd1);
    cyc(0, 0, 0, 8'h00, 1);
    chk("busy_fall", {31'b0, busy_a}, 32'd0);
    chk("two_wc", {23'b0, wc_a}, 32'd2);
    fetch(0, 32'h00400000, 32'h20080013, "two_w0");
    fetch(0, 32'h00400004, 32'h21090013, "two_w1");
    fetch(0, 32'h00400002, 32'h00000000, "misaligned");

    // Five bytes, end coincident with the last byte.
    cyc(0, 1, 0, 8'h00, 0);
    cyc(0, 0, 1, 8'hAA, 0); cyc(0, 0, 1, 8'hBB, 0);
    cyc(0, 0, 1, 8'hCC, 0); cyc(0, 0, 1, 8'hDD, 0);
    cyc(0, 0, 1, 8'hEE, 1);
    chk("five_wc", {23'b0, wc_a}, 32'd2);
    chk("five_busy", {31'b0, busy_a}, 32'd0);
    fetch(0, 32'h00400000, 32'hDDCCBBAA, "five_w0");
    fetch(0, 32'h00400004, 32'h000000EE, "five_w1");
    fetch(0, 32'h00400008, 32'hC0DE0002, "five_w2_kept");
    fetch(0, 32'h004003FC, 32'hC0DE00FF, "five_last_kept");

    // Restart mid-load drops the partial word.
    cyc(0, 1, 0, 8'h00, 0);
    cyc(0, 0, 1, 8'h11, 0); cyc(0, 0, 1, 8'h22, 0);
    cyc(0, 0, 1, 8'h33, 0); cyc(0, 0, 1, 8'h44, 0);
    cyc(0, 0, 1, 8'h55, 0); cyc(0, 0, 1, 8'h66, 0);
    chk("rs_wc_pre", {23'b0, wc_a}, 32'd1);
    cyc(0, 1, 0, 8'h00, 0);
    chk("rs_busy", {31'b0, busy_a}, 32'd1);
    chk("rs_wc", {23'b0, wc_a}, 32'd0);
    cyc(0, 0, 1, 8'h01, 0); cyc(0, 0, 1, 8'h02, 0);
    cyc(0, 0, 1, 8'h03, 0); cyc(0, 0, 1, 8'h04, 0);
    cyc(0, 0, 0, 8'h00, 1);
    chk("rs_wc_end", {23'b0, wc_a}, 32'd1);
    fetch(0, 32'h00400000, 32'h04030201, "rs_w0");
    fetch(0, 32'h00400004, 32'h000000EE, "rs_w1");

    // Asynchronous reset after six bytes.
    cyc(0, 1, 0, 8'h00, 0);
    cyc(0, 0, 1, 8'h10, 0); cyc(0, 0, 1, 8'h11, 0);
    cyc(0, 0, 1, 8'h12, 0); cyc(0, 0, 1, 8'h13, 0);
    cyc(0, 0, 1, 8'h14, 0); cyc(0, 0, 1, 8'h15, 0);
    #2 rst = 1'b1;
    #1;
    chk("ar_busy", {31'b0, busy_a}, 32'd0);
    chk("ar_wc", {23'b0, wc_a}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(0, 0, 1, 8'h99, 1);
    chk("idle_ignore_busy", {31'b0, busy_a}, 32'd0);
    chk("idle_ignore_wc", {23'b0, wc_a}, 32'd0);
    fetch(0, 32'h00400000, 32'h13121110, "ar_w0");
    fetch(0, 32'h00400004, 32'h000000EE, "ar_w1");

    // Overflow on the 4-word instance.
    cyc(1, 1, 0, 8'h00, 0);
    for (int i = 0; i < 16; i++) cyc(1, 0, 1, 8'(i), 0);
    chk("ov_err_at_full", {31'b0, err_b}, 32'd0);
    chk("ov_wc_at_full", {29'b0, wc_b}, 32'd4);
    for (int i = 16; i < 20; i++) cyc(1, 0, 1, 8'(i), 0);
    chk("ov_err", {31'b0, err_b}, 32'd1);
    cyc(1, 0, 0, 8'h00, 1);
    chk("ov_wc", {29'b0, wc_b}, 32'd4);
    chk("ov_err_sticky", {31'b0, err_b}, 32'd1);
    fetch(1, 32'h00400000, 32'h03020100, "ov_w0");
    fetch(1, 32'h00400004, 32'h07060504, "ov_w1");
    fetch(1, 32'h00400008, 32'h0B0A0908, "ov_w2");
    fetch(1, 32'h0040000C, 32'h0F0E0D0C, "ov_w3");
    fetch(1, 32'h00400010, 32'h00000000, "ov_past_end");
    cyc(1, 1, 0, 8'h00, 0);
    chk("ov_err_clr", {31'b0, err_b}, 32'd0);
    chk("ov_wc_clr", {29'b0, wc_b}, 32'd0);
    cyc(1, 0, 0, 8'h00, 1);
    chk("ov_idle", {31'b0, busy_b}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
